plru_multiset: RTL and testbench

PLRU_MULTISET -- requirements
Module: plru_multiset

---
 rtl/plru_multiset_pkg.sv | 26 ++
 rtl/plru_tree_walk.sv | 59 +++++
 rtl/plru_multiset.sv | 166 ++++++++++++++++
 tb/tb_plru_multiset.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/plru_multiset_pkg.sv
// Shared definitions for the multi-set pseudo-LRU victim selector:
// parameter limits, width derivations and the request FSM encoding.
package plru_multiset_pkg;

    localparam int WAYS_MIN = 2;
    localparam int WAYS_MAX = 64;
    localparam int SETS_MIN = 1;
    localparam int SETS_MAX = 256;

    // Set index width; a single-set build still carries a 1-bit index port.
    function automatic int set_w_f(input int sets);
        return (sets <= 1) ? 1 : $clog2(sets);
    endfunction

    // A binary tree over WAYS leaves has WAYS-1 internal nodes.
    function automatic int nodes_f(input int ways);
        return ways - 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/plru_tree_walk.sv
// Combinational PLRU tree helper. One tree walk (tree bits -> one-hot
// victim) plus N_UPD independent access-path generators (one-hot way ->
// node mask and node values that point away from that way).
// Heap indexing: node n has children 2n+1 (lower half) and 2n+2 (upper).
module plru_tree_walk
    import plru_multiset_pkg::*;
#(
    parameter  int WAYS   = 32,
    parameter  int N_UPD  = 2,
    localparam int NODES  = nodes_f(WAYS),
    localparam int LEVELS = $clog2(WAYS)
) (
    input  logic [NODES-1:0]            tree_bits,
    output logic [WAYS-1:0]             victim_oh,
    input  logic [N_UPD-1:0][WAYS-1:0]  acc_way,
    output logic [N_UPD-1:0][NODES-1:0] upd_mask,
    output logic [N_UPD-1:0][NODES-1:0] upd_val
);

    // Follow the node bits from the root: 0 -> lower half, 1 -> upper half.
    always_comb begin
        int  node_i;
        int  idx_i;
        logic b;
        node_i = 0;
        idx_i  = 0;
        b      = 1'b0;
        for (int l = 0; l < LEVELS; l++) begin
            b      = tree_bits[LEVELS'(node_i)];
            idx_i  = idx_i * 2 + int'(b);
            node_i = node_i * 2 + 1 + int'(b);
        end
        victim_oh = {{(WAYS-1){1'b0}}, 1'b1} << idx_i;
    end

    for (genvar g = 0; g < N_UPD; g++) begin : g_upd
        // Mark every node on the accessed way's path and point it away.
        always_comb begin
            int  idx_i;
            int  node_i;
            int  b;
            idx_i  = 0;
            node_i = 0;
            b      = 0;
            for (int w = 0; w < WAYS; w++) begin
                if (acc_way[g][w]) idx_i = idx_i | w;
            end
            upd_mask[g] = '0;
            upd_val[g]  = '0;
            for (int l = 0; l < LEVELS; l++) begin
                b = (idx_i >> (LEVELS - 1 - l)) & 1;
                upd_mask[g][LEVELS'(node_i)] = 1'b1;
                upd_val[g][LEVELS'(node_i)]  = (b == 0);
                node_i = node_i * 2 + 1 + b;
            end
        end
    end

endmodule

// File: rtl/plru_multiset.sv
// Multi-set pseudo-LRU replacement block. Hits update the tree of their set
// in any state; a refill request runs IDLE -> SEL -> RESP and returns a
// one-hot victim (lowest invalid way first, otherwise the tree walk).
// Handshake: a refill is accepted on an edge where refill_vld and refill_rdy
// are both high; the victim is held with victim_vld until the edge where
// victim_ack is high, and victim_ack outside RESP has no effect.
module plru_multiset
    import plru_multiset_pkg::*;
#(
    parameter  int WAYS  = 32,
    parameter  int SETS  = 1,
    localparam int SET_W = set_w_f(SETS),
    localparam int NODES = nodes_f(WAYS)
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             flush,
    input  logic             hit_vld,
    input  logic [SET_W-1:0] hit_set,
    input  logic [WAYS-1:0]  hit_way,
    input  logic             refill_vld,
    output logic             refill_rdy,
    input  logic [SET_W-1:0] refill_set,
    input  logic [WAYS-1:0]  refill_entry_vld,
    output logic             victim_vld,
    output logic [WAYS-1:0]  victim_way,
    output logic [SET_W-1:0] victim_set,
    input  logic             victim_ack,
    output logic             hit_err,
    output logic [1:0]       dbg_state
);

    localparam logic [SET_W-1:0] SET_MASK = SET_W'(SETS - 1);

    logic [NODES-1:0] tree_q [SETS];
    logic [NODES-1:0] tree_d [SETS];

    state_e           state_q, state_d;
    logic [SET_W-1:0] req_set_q, req_set_d;
    logic [WAYS-1:0]  req_vld_q, req_vld_d;
    logic [WAYS-1:0]  victim_way_q, victim_way_d;
    logic [SET_W-1:0] victim_set_q, victim_set_d;
    logic             victim_vld_q, victim_vld_d;
    logic             hit_err_q, hit_err_d;

    logic             hit_onehot;
    logic             hit_ok;
    logic [SET_W-1:0] hit_idx;
    logic [WAYS-1:0]  walk_victim;
    logic [WAYS-1:0]  invalid_ways;
    logic [WAYS-1:0]  sel_victim;
    logic [1:0][WAYS-1:0]  acc_way;
    logic [1:0][NODES-1:0] upd_mask;
    logic [1:0][NODES-1:0] upd_val;

    // Hit qualification; masking the index keeps SETS = 1 at set 0.
    always_comb begin
        hit_onehot = (hit_way != '0) && ((hit_way & (hit_way - WAYS'(1))) == '0);
        hit_ok     = hit_vld && hit_onehot;
        hit_idx    = hit_set & SET_MASK;
    end

    // Victim choice for the captured request: first invalid way wins.
    always_comb begin
        invalid_ways = ~req_vld_q;
        if (invalid_ways != '0) begin
            sel_victim = invalid_ways & (~invalid_ways + WAYS'(1));
        end else begin
            sel_victim = walk_victim;
        end
        acc_way[0] = hit_way;
        acc_way[1] = sel_victim;
    end

    plru_tree_walk #(
        .WAYS  (WAYS),
        .N_UPD (2)
    ) u_tree_walk (
        .tree_bits (tree_q[req_set_q]),
        .victim_oh (walk_victim),
        .acc_way   (acc_way),
        .upd_mask  (upd_mask),
        .upd_val   (upd_val)
    );

    // Tree next state: hit first, victim update layered on top, flush last.
    always_comb begin
        for (int s = 0; s < SETS; s++) tree_d[s] = tree_q[s];
        if (hit_ok) begin
            tree_d[hit_idx] = (tree_q[hit_idx] & ~upd_mask[0]) | (upd_val[0] & upd_mask[0]);
        end
        if (state_q == ST_SEL) begin
            tree_d[req_set_q] = (tree_d[req_set_q] & ~upd_mask[1]) | (upd_val[1] & upd_mask[1]);
        end
        if (flush) begin
            for (int s = 0; s < SETS; s++) tree_d[s] = '0;
        end
    end

    // Request FSM and registered victim outputs.
    always_comb begin
        state_d      = state_q;
        req_set_d    = req_set_q;
        req_vld_d    = req_vld_q;
        victim_way_d = victim_way_q;
        victim_set_d = victim_set_q;
        victim_vld_d = victim_vld_q;
        hit_err_d    = hit_vld && !hit_onehot;
        unique case (state_q)
            ST_IDLE: begin
                if (refill_vld) begin
                    state_d   = ST_SEL;
                    req_set_d = refill_set & SET_MASK;
                    req_vld_d = refill_entry_vld;
                end
            end
            ST_SEL: begin
                state_d      = ST_RESP;
                victim_way_d = sel_victim;
                victim_set_d = req_set_q;
                victim_vld_d = 1'b1;
            end
            ST_RESP: begin
                if (victim_ack) begin
                    state_d      = ST_IDLE;
                    victim_vld_d = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                victim_vld_d = 1'b0;
            end
        endcase
    end

    // All state registers; reset drops any pending request.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
            state_q      <= ST_IDLE;
            req_set_q    <= '0;
            req_vld_q    <= '0;
            victim_way_q <= '0;
            victim_set_q <= '0;
            victim_vld_q <= 1'b0;
            hit_err_q    <= 1'b0;
        end else begin
            for (int s = 0; s < SETS; s++) tree_q[s] <= tree_d[s];
            state_q      <= state_d;
            req_set_q    <= req_set_d;
            req_vld_q    <= req_vld_d;
            victim_way_q <= victim_way_d;
            victim_set_q <= victim_set_d;
            victim_vld_q <= victim_vld_d;
            hit_err_q    <= hit_err_d;
        end
    end

    assign refill_rdy = (state_q == ST_IDLE);
    assign victim_vld = victim_vld_q;
    assign victim_way = victim_way_q;
    assign victim_set = victim_set_q;
    assign hit_err    = hit_err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_plru_multiset.sv
module tb_plru_multiset;
  localparam int WAYS  = 8;
  localparam int SETS  = 4;
  localparam int SET_W = 2;

  logic             clk = 1'b0;
  logic             cpurst_b;
  logic             flush;
  logic             hit_vld;
  logic [SET_W-1:0] hit_set;
  logic [WAYS-1:0]  hit_way;
  logic             refill_vld;
  logic             refill_rdy;
  logic [SET_W-1:0] refill_set;
  logic [WAYS-1:0]  refill_entry_vld;
  logic             victim_vld;
  logic [WAYS-1:0]  victim_way;
  logic [SET_W-1:0] victim_set;
  logic             victim_ack;
  logic             hit_err;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [WAYS-1:0] exp_q[$];

  plru_multiset #(.WAYS(WAYS), .SETS(SETS)) dut (
    .forever_cpuclk   (clk),
    .cpurst_b         (cpurst_b),
    .flush            (flush),
    .hit_vld          (hit_vld),
    .hit_set          (hit_set),
    .hit_way          (hit_way),
    .refill_vld       (refill_vld),
    .refill_rdy       (refill_rdy),
    .refill_set       (refill_set),
    .refill_entry_vld (refill_entry_vld),
    .victim_vld       (victim_vld),
    .victim_way       (victim_way),
    .victim_set       (victim_set),
    .victim_ack       (victim_ack),
    .hit_err          (hit_err),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    cpurst_b = 1'b0;
    tick();
    tick();
    cpurst_b = 1'b1;
  endtask

  // driver tasks
  task automatic do_hit(input logic [SET_W-1:0] s, input logic [WAYS-1:0] w);
    hit_vld = 1'b1;
    hit_set = s;
    hit_way = w;
    tick();
    hit_vld = 1'b0;
    hit_way = '0;
  endtask

  // Issue a refill, optionally with a same-edge hit at accept (acc_*) and a
  // hit during SEL (sel_*); check latency, victim, and ack return to idle.
  task automatic do_refill(input string tag, input logic [SET_W-1:0] s,
                           input logic [WAYS-1:0] vld, input logic [WAYS-1:0] exp_way,
                           input logic acc_hit, input logic [SET_W-1:0] acc_set,
                           input logic [WAYS-1:0] acc_way,
                           input logic sel_hit, input logic [SET_W-1:0] sel_set,
                           input logic [WAYS-1:0] sel_way);
    logic [WAYS-1:0] exp_w;
    int budget;
    budget = 0;
    while (!refill_rdy && budget < 20) begin
      tick();
      budget++;
    end
    if (!refill_rdy) check({tag, "_rdy_timeout"}, 64'(refill_rdy), 64'd1);
    exp_q.push_back(exp_way);
    refill_vld       = 1'b1;
    refill_set       = s;
    refill_entry_vld = vld;
    hit_vld          = acc_hit;
    hit_set          = acc_set;
    hit_way          = acc_way;
    tick();
    refill_vld = 1'b0;
    hit_vld    = sel_hit;
    hit_set    = sel_set;
    hit_way    = sel_way;
    check({tag, "_vld_early"}, 64'(victim_vld), 64'd0);
    tick();
    hit_vld = 1'b0;
    hit_way = '0;
    exp_w = exp_q.pop_front();
    check({tag, "_vld"}, 64'(victim_vld), 64'd1);
    check({tag, "_way"}, 64'(victim_way), 64'(exp_w));
    check({tag, "_set"}, 64'(victim_set), 64'(s));
    victim_ack = 1'b1;
    tick();
    victim_ack = 1'b0;
    check({tag, "_vld_after_ack"}, 64'(victim_vld), 64'd0);
  endtask

  task automatic refill_simple(input string tag, input logic [SET_W-1:0] s,
                               input logic [WAYS-1:0] vld, input logic [WAYS-1:0] exp_way);
    do_refill(tag, s, vld, exp_way, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    cpurst_b = 1'b0; flush = 1'b0; hit_vld = 1'b0; hit_set = '0; hit_way = '0;
    refill_vld = 1'b0; refill_set = '0; refill_entry_vld = '0; victim_ack = 1'b0;

    // reset state
    do_reset();
    check("rst_vld", 64'(victim_vld), 64'd0);
    check("rst_way", 64'(victim_way), 64'd0);
    check("rst_set", 64'(victim_set), 64'd0);
    check("rst_hit_err", 64'(hit_err), 64'd0);
    check("rst_rdy", 64'(refill_rdy), 64'd1);
    check("rst_state", 64'(dbg_state), 64'd0);

    // three refills to set 0, all valid
    refill_simple("seq0", 2'd0, 8'hFF, 8'h01);
    refill_simple("seq1", 2'd0, 8'hFF, 8'h10);
    refill_simple("seq2", 2'd0, 8'hFF, 8'h04);

    // independent sets
    do_reset();
    do_hit(2'd1, 8'h01);
    refill_simple("set1", 2'd1, 8'hFF, 8'h10);
    refill_simple("set2", 2'd2, 8'hFF, 8'h01);

    // invalid-way priority
    refill_simple("inv_f7", 2'd2, 8'hF7, 8'h08);
    refill_simple("inv_00", 2'd3, 8'h00, 8'h01);

    // hit on the accept edge, then a multi-hot hit
    do_reset();
    do_refill("acc_hit", 2'd0, 8'hFF, 8'h10, 1'b1, 2'd0, 8'h01, 1'b0, '0, '0);
    hit_vld = 1'b1; hit_set = 2'd0; hit_way = 8'h03;
    tick();
    hit_vld = 1'b0; hit_way = '0;
    check("bad_hit_err", 64'(hit_err), 64'd1);
    tick();
    check("bad_hit_err_clr", 64'(hit_err), 64'd0);
    refill_simple("bad_hit_tree", 2'd0, 8'hFF, 8'h04);

    // zero hit_way also flags an error
    do_hit(2'd1, 8'h00);
    check("zero_hit_err", 64'(hit_err), 64'd1);

    // same-set hit during SEL: victim update wins shared nodes
    do_reset();
    do_refill("sel_same", 2'd0, 8'hFF, 8'h01, 1'b0, '0, '0, 1'b1, 2'd0, 8'h10);
    refill_simple("sel_same_after", 2'd0, 8'hFF, 8'h40);

    // different-set hit during SEL
    do_refill("sel_diff", 2'd2, 8'hFF, 8'h01, 1'b0, '0, '0, 1'b1, 2'd1, 8'h01);
    refill_simple("sel_diff_after", 2'd1, 8'hFF, 8'h10);

    // withheld ack, flush in RESP, then reset in RESP
    do_reset();
    refill_vld = 1'b1; refill_set = 2'd0; refill_entry_vld = 8'hFF;
    victim_ack = 1'b0;
    tick();
    refill_vld = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_vld", 64'(victim_vld), 64'd1);
      check("hold_way", 64'(victim_way), 64'h01);
      check("hold_rdy", 64'(refill_rdy), 64'd0);
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_resp_vld", 64'(victim_vld), 64'd1);
    check("flush_resp_way", 64'(victim_way), 64'h01);
    cpurst_b = 1'b0;
    tick();
    cpurst_b = 1'b1;
    check("rst_resp_vld", 64'(victim_vld), 64'd0);
    check("rst_resp_rdy", 64'(refill_rdy), 64'd1);
    refill_simple("post_rst", 2'd0, 8'hFF, 8'h01);

    // flush after updates, and flush beating a same-edge hit
    do_hit(2'd0, 8'h01);
    do_hit(2'd0, 8'h20);
    flush = 1'b1;
    hit_vld = 1'b1; hit_set = 2'd1; hit_way = 8'h01;
    tick();
    flush = 1'b0; hit_vld = 1'b0; hit_way = '0;
    refill_simple("flush0", 2'd0, 8'hFF, 8'h01);
    refill_simple("flush1", 2'd1, 8'hFF, 8'h01);

    // ack outside RESP is ignored
    victim_ack = 1'b1;
    tick();
    victim_ack = 1'b0;
    check("stray_ack_rdy", 64'(refill_rdy), 64'd1);
    refill_simple("stray_ack", 2'd0, 8'hFF, 8'h10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
